// File: rtl/multicycle_ctrl.sv
// Moore FSM controller for a multicycle MIPS-subset datapath.
// Optional MULTICYCLE_PERF_EN adds cycle/instruction counters.
module multicycle_ctrl #(
  parameter int unsigned WAIT_MAX = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] Op_i,
  input  logic       Zero_i,
  input  logic       mem_ready_i,
  output logic       PCWrite_o,
  output logic       IorD_o,
  output logic       MemRead_o,
  output logic       MemWrite_o,
  output logic       IRWrite_o,
  output logic       RegDst_o,
  output logic       MemtoReg_o,
  output logic       RegWrite_o,
  output logic       ALUSrcA_o,
  output logic [1:0] ALUSrcB_o,
  output logic [1:0] ALUOp_o,
  output logic [1:0] PCSource_o,
  output logic       illegal_o,
  output logic       mem_timeout_o,
  output logic [3:0] state_o
`ifdef MULTICYCLE_PERF_EN
  ,
  output logic [31:0] cycle_cnt_o,
  output logic [31:0] instr_cnt_o
`endif
);

  typedef enum logic [3:0] {
    S_RST     = 4'd0,
    S_IF      = 4'd1,
    S_ID      = 4'd2,
    S_EX_R    = 4'd3,
    S_EX_ADDR = 4'd4,
    S_EX_ADDI = 4'd5,
    S_EX_BEQ  = 4'd6,
    S_EX_J    = 4'd7,
    S_MEM_RD  = 4'd8,
    S_MEM_WR  = 4'd9,
    S_WB_R    = 4'd10,
    S_WB_LW   = 4'd11,
    S_WB_ADDI = 4'd12,
    S_HALT    = 4'd13
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [7:0] WMAX = WAIT_MAX[7:0];
  localparam logic       TMO_EN = (WAIT_MAX != 0);

  state_t     st;
  state_t     nxt;
  logic [7:0] wait_cnt;
  logic       tmo_flag;
  logic       tmo_hit;
  logic       mem_st;

  assign mem_st  = (st == S_IF) || (st == S_MEM_RD) ||
                   (st == S_MEM_WR);
  assign tmo_hit = TMO_EN && (wait_cnt == WMAX) && !mem_ready_i;

  assign state_o       = st;
  assign mem_timeout_o = tmo_flag;

  // Next-state and control decode from the current state.
  always_comb begin
    nxt        = st;
    PCWrite_o  = 1'b0;
    IorD_o     = 1'b0;
    MemRead_o  = 1'b0;
    MemWrite_o = 1'b0;
    IRWrite_o  = 1'b0;
    RegDst_o   = 1'b0;
    MemtoReg_o = 1'b0;
    RegWrite_o = 1'b0;
    ALUSrcA_o  = 1'b0;
    ALUSrcB_o  = 2'b00;
    ALUOp_o    = 2'b00;
    PCSource_o = 2'b00;
    illegal_o  = 1'b0;
    unique case (st)
      S_RST: nxt = S_IF;
      S_IF: begin
        MemRead_o = 1'b1;
        ALUSrcB_o = 2'b01;
        IRWrite_o = mem_ready_i;
        PCWrite_o = mem_ready_i;
        if (mem_ready_i) nxt = S_ID;
        else if (tmo_hit) nxt = S_HALT;
      end
      S_ID: begin
        ALUSrcB_o = 2'b11;
        case (Op_i)
          OP_R:         nxt = S_EX_R;
          OP_ADDI:      nxt = S_EX_ADDI;
          OP_LW, OP_SW: nxt = S_EX_ADDR;
          OP_BEQ:       nxt = S_EX_BEQ;
          OP_J:         nxt = S_EX_J;
          default: begin
            illegal_o = 1'b1;
            nxt       = S_IF;
          end
        endcase
      end
      S_EX_R: begin
        ALUSrcA_o = 1'b1;
        ALUOp_o   = 2'b11;
        nxt       = S_WB_R;
      end
      S_EX_ADDI: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = 2'b10;
        nxt       = S_WB_ADDI;
      end
      S_EX_ADDR: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = 2'b10;
        nxt = (Op_i == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_EX_BEQ: begin
        ALUSrcA_o  = 1'b1;
        ALUOp_o    = 2'b01;
        PCSource_o = 2'b01;
        PCWrite_o  = Zero_i;
        nxt        = S_IF;
      end
      S_EX_J: begin
        PCSource_o = 2'b10;
        PCWrite_o  = 1'b1;
        nxt        = S_IF;
      end
      S_MEM_RD: begin
        MemRead_o = 1'b1;
        IorD_o    = 1'b1;
        if (mem_ready_i) nxt = S_WB_LW;
        else if (tmo_hit) nxt = S_HALT;
      end
      S_MEM_WR: begin
        MemWrite_o = 1'b1;
        IorD_o     = 1'b1;
        if (mem_ready_i) nxt = S_IF;
        else if (tmo_hit) nxt = S_HALT;
      end
      S_WB_R: begin
        RegDst_o   = 1'b1;
        RegWrite_o = 1'b1;
        nxt        = S_IF;
      end
      S_WB_LW: begin
        MemtoReg_o = 1'b1;
        RegWrite_o = 1'b1;
        nxt        = S_IF;
      end
      S_WB_ADDI: begin
        RegWrite_o = 1'b1;
        nxt        = S_IF;
      end
      S_HALT: nxt = S_HALT;
      default: nxt = S_RST;
    endcase
  end

  // State register, stall counter and sticky timeout flag.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      st       <= S_RST;
      wait_cnt <= 8'd0;
      tmo_flag <= 1'b0;
    end else begin
      st <= nxt;
      if (nxt != st) wait_cnt <= 8'd0;
      else if (mem_st && !mem_ready_i)
        wait_cnt <= wait_cnt + 8'd1;
      if (nxt == S_HALT) tmo_flag <= 1'b1;
    end
  end

`ifdef MULTICYCLE_PERF_EN
  logic retire;
  assign retire = (nxt == S_IF) &&
                  ((st == S_EX_BEQ) || (st == S_EX_J) ||
                   (st == S_MEM_WR) || (st == S_WB_R) ||
                   (st == S_WB_LW) || (st == S_WB_ADDI));

  // Active-cycle and retired-instruction counters.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cycle_cnt_o <= 32'd0;
      instr_cnt_o <= 32'd0;
    end else begin
      if (st != S_RST && st != S_HALT)
        cycle_cnt_o <= cycle_cnt_o + 32'd1;
      if (retire) instr_cnt_o <= instr_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl (WAIT_MAX=4).
// Per-instruction cycle-list model; perf counters when enabled.
module tb_multicycle_ctrl;

  localparam int WM = 4;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;

  logic       clk = 1'b0;
  logic       rst_i = 1'b0;
  logic [5:0] Op_i = 6'd0;
  logic       Zero_i = 1'b0;
  logic       mem_ready_i = 1'b0;
  logic       PCWrite_o, IorD_o, MemRead_o, MemWrite_o;
  logic       IRWrite_o, RegDst_o, MemtoReg_o, RegWrite_o;
  logic       ALUSrcA_o, illegal_o, mem_timeout_o;
  logic [1:0] ALUSrcB_o, ALUOp_o, PCSource_o;
  logic [3:0] state_o;
`ifdef MULTICYCLE_PERF_EN
  logic [31:0] cycle_cnt_o, instr_cnt_o;
`endif

  int checks = 0;
  int failures = 0;
  int m_cyc = 0;
  int m_ins = 0;
  logic [5:0] cur_op = 6'd0;
  logic [16:0] obs;

  multicycle_ctrl #(.WAIT_MAX(WM)) dut (
    .clk_i(clk), .rst_i(rst_i), .Op_i(Op_i),
    .Zero_i(Zero_i), .mem_ready_i(mem_ready_i),
    .PCWrite_o(PCWrite_o), .IorD_o(IorD_o),
    .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o),
    .IRWrite_o(IRWrite_o), .RegDst_o(RegDst_o),
    .MemtoReg_o(MemtoReg_o), .RegWrite_o(RegWrite_o),
    .ALUSrcA_o(ALUSrcA_o), .ALUSrcB_o(ALUSrcB_o),
    .ALUOp_o(ALUOp_o), .PCSource_o(PCSource_o),
    .illegal_o(illegal_o), .mem_timeout_o(mem_timeout_o),
    .state_o(state_o)
`ifdef MULTICYCLE_PERF_EN
    ,
    .cycle_cnt_o(cycle_cnt_o),
    .instr_cnt_o(instr_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  assign obs = {PCWrite_o, IorD_o, MemRead_o, MemWrite_o,
                IRWrite_o, RegDst_o, MemtoReg_o, RegWrite_o,
                ALUSrcA_o, ALUSrcB_o, ALUOp_o, PCSource_o,
                illegal_o, mem_timeout_o};

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic legal(input logic [5:0] op);
    return op == OP_R || op == OP_ADDI || op == OP_LW ||
           op == OP_SW || op == OP_BEQ || op == OP_J;
  endfunction

  // Control vector each state must show, from the state table.
  function automatic logic [16:0] ctl(input int st,
      input logic rdy, input logic z, input logic [5:0] op);
    logic pcw, iord, mr, mw, irw, rd, m2r, rw, sa, ill, to;
    logic [1:0] sb, aop, ps;
    {pcw, iord, mr, mw, irw, rd, m2r, rw, sa, ill, to} = '0;
    sb = 2'd0; aop = 2'd0; ps = 2'd0;
    case (st)
      1: begin mr = 1; sb = 2'd1; irw = rdy; pcw = rdy; end
      2: begin sb = 2'd3; ill = !legal(op); end
      3: begin sa = 1; aop = 2'd3; end
      4, 5: begin sa = 1; sb = 2'd2; end
      6: begin sa = 1; aop = 2'd1; ps = 2'd1; pcw = z; end
      7: begin ps = 2'd2; pcw = 1; end
      8: begin mr = 1; iord = 1; end
      9: begin mw = 1; iord = 1; end
      10: begin rd = 1; rw = 1; end
      11: begin m2r = 1; rw = 1; end
      12: rw = 1;
      13: to = 1;
      default: ;
    endcase
    return {pcw, iord, mr, mw, irw, rd, m2r, rw, sa, sb, aop,
            ps, ill, to};
  endfunction

  task automatic chk_state(input int exp, input string tag);
    logic [3:0] e;
    e = exp[3:0];
    checks++;
    assert (state_o === e) else begin
      failures++;
      $error("FAIL %s state got=%0d exp=%0d", tag, state_o, e);
    end
  endtask

  task automatic chk_ctl(input logic [16:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s ctl got=%b exp=%b", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic rdy, input logic z,
                     input int exp, input string tag);
    @(negedge clk);
    mem_ready_i = rdy;
    Zero_i = z;
    Op_i = cur_op;
    #1;
    chk_state(exp, tag);
    chk_ctl(ctl(exp, rdy, z, cur_op), tag);
    if (exp != 0 && exp != 13) m_cyc++;
  endtask

  task automatic chk_perf(input string tag);
`ifdef MULTICYCLE_PERF_EN
    @(posedge clk);
    #1;
    checks++;
    assert (cycle_cnt_o === 32'(m_cyc)) else begin
      failures++;
      $error("FAIL %s cycle_cnt got=%0d exp=%0d", tag,
             cycle_cnt_o, m_cyc);
    end
    checks++;
    assert (instr_cnt_o === 32'(m_ins)) else begin
      failures++;
      $error("FAIL %s instr_cnt got=%0d exp=%0d", tag,
             instr_cnt_o, m_ins);
    end
`endif
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    chk_state(0, tag);
    chk_ctl(17'd0, tag);
    m_cyc = 0;
    m_ins = 0;
    @(negedge clk);
    rst_i = 1'b1;
    mem_ready_i = rb();
    #1;
    chk_state(0, tag);
    chk_ctl(17'd0, tag);
  endtask

  // Walk one instruction through the expected state sequence.
  task automatic run_instr(input logic [5:0] op, input logic z,
      input int s_if, input int s_mem, input string tag);
    int ms, k;
    cur_op = op;
    for (int i = 0; i < s_if; i++) cyc(1'b0, rb(), 1, tag);
    cyc(1'b1, rb(), 1, tag);
    cyc(rb(), rb(), 2, tag);
    if (!legal(op)) return;
    case (op)
      OP_R: begin
        cyc(rb(), rb(), 3, tag);
        cyc(rb(), rb(), 10, tag);
      end
      OP_ADDI: begin
        cyc(rb(), rb(), 5, tag);
        cyc(rb(), rb(), 12, tag);
      end
      OP_BEQ: cyc(rb(), z, 6, tag);
      OP_J: cyc(rb(), rb(), 7, tag);
      default: begin
        ms = (op == OP_LW) ? 8 : 9;
        cyc(rb(), rb(), 4, tag);
        k = (s_mem > WM) ? WM + 1 : s_mem;
        for (int i = 0; i < k; i++) cyc(1'b0, rb(), ms, tag);
        if (s_mem > WM) begin
          cyc(rb(), rb(), 13, tag);
          cyc(rb(), rb(), 13, tag);
          do_reset({tag, "_rst"});
          return;
        end
        cyc(1'b1, rb(), ms, tag);
        if (op == OP_LW) cyc(rb(), rb(), 11, tag);
      end
    endcase
    m_ins++;
    chk_perf(tag);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] ops[6];
    logic [5:0] op;
    ops[0] = OP_R;  ops[1] = OP_ADDI; ops[2] = OP_LW;
    ops[3] = OP_SW; ops[4] = OP_BEQ;  ops[5] = OP_J;

    do_reset("reset");
    run_instr(OP_R, 1'b0, 0, 0, "rtype");
    run_instr(OP_LW, 1'b0, 0, 3, "lw_stall3");
    run_instr(OP_BEQ, 1'b1, 0, 0, "beq_taken");
    run_instr(OP_BEQ, 1'b0, 0, 0, "beq_not");
    run_instr(6'b111111, 1'b0, 0, 0, "illegal");
    run_instr(OP_ADDI, 1'b0, 2, 0, "addi_ifstall");
    run_instr(OP_SW, 1'b0, 0, WM, "sw_edge");
    run_instr(OP_SW, 1'b0, 0, 50, "sw_timeout");

    run_instr(OP_J, 1'b0, 0, 0, "perf_j");
    run_instr(OP_ADDI, 1'b0, 0, 0, "perf_addi");
    run_instr(OP_SW, 1'b0, 0, 0, "perf_sw");
`ifdef MULTICYCLE_PERF_EN
    checks++;
    assert (instr_cnt_o === 32'd3) else begin
      failures++;
      $error("FAIL perf_seq instr got=%0d exp=3", instr_cnt_o);
    end
    checks++;
    assert (cycle_cnt_o === 32'd11) else begin
      failures++;
      $error("FAIL perf_seq cycle got=%0d exp=11", cycle_cnt_o);
    end
`endif

    cur_op = OP_R;
    cyc(1'b1, 1'b0, 1, "midrst");
    cyc(1'b1, 1'b0, 2, "midrst");
    cyc(1'b1, 1'b0, 3, "midrst");
    do_reset("midrst_rst");

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        do op = 6'($urandom); while (legal(op));
      end else begin
        op = ops[$urandom_range(0, 5)];
      end
      run_instr(op, rb(), $urandom_range(0, WM),
                $urandom_range(0, WM + 2), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore FSM controller for the multicycle MIPS-subset datapath: R-type, addi, lw, sw, beq, j.
- Sequences a shared instruction/data memory, IR, ALU, register file and PC across IF/ID/EX/MEM/WB.
- Adds memory wait-state handshake, wait timeout and illegal-opcode detection.
- Replaces the single-cycle decoder once the datapath goes multicycle; the ALU control block still consumes ALUOp_o.

Parameters:
- WAIT_MAX, 16, maximum consecutive stalled cycles in one memory state before halting; 0 disables the timeout; range 0..255.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- Op_i  in  6  IR[31:26], valid from ID onward
- Zero_i  in  1  ALU zero flag
- mem_ready_i  in  1  memory completes the current read/write this cycle
- PCWrite_o  out  1  PC load enable
- IorD_o  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead_o  out  1  memory read request
- MemWrite_o  out  1  memory write request
- IRWrite_o  out  1  IR load enable
- RegDst_o  out  1  write register select: 1 = rd, 0 = rt
- MemtoReg_o  out  1  register write data select: 1 = MDR, 0 = ALUOut
- RegWrite_o  out  1  register file write enable
- ALUSrcA_o  out  1  ALU A select: 0 = PC, 1 = register A
- ALUSrcB_o  out  2  ALU B select: 00 = register B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm<<2
- ALUOp_o  out  2  00 = ADD, 01 = SUB, 11 = RTYPE
- PCSource_o  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- illegal_o  out  1  one-cycle pulse on an undecodable opcode
- mem_timeout_o  out  1  sticky memory timeout flag
- state_o  out  4  current state encoding, for debug

Behaviour:
- States and encodings: RST=0, IF=1, ID=2, EX_R=3, EX_ADDR=4, EX_ADDI=5, EX_BEQ=6, EX_J=7, MEM_RD=8, MEM_WR=9, WB_R=10, WB_LW=11, WB_ADDI=12, HALT=13.
- Reset: asynchronous to RST. In RST every output is 0 except state_o=0. RST always goes to IF on the next edge.
- Outputs are decoded from state only, except PCWrite_o in EX_BEQ and the stall gating below. Any output not listed for a state is 0.
- IF:
  - Drive MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite and PCWrite equal mem_ready_i.
  - Stay in IF while mem_ready_i=0; go to ID on mem_ready_i=1.
- ID:
  - Drive ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target precompute).
  - Next state by opcode: 000000 -> EX_R; 001000 -> EX_ADDI; 100011 or 101011 -> EX_ADDR; 000100 -> EX_BEQ; 000010 -> EX_J.
  - Any other opcode: illegal_o=1 for this cycle, next state IF. The already-incremented PC skips the instruction.
- EX_R: ALUSrcA=1, ALUSrcB=00, ALUOp=11 -> WB_R.
- EX_ADDI: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> WB_ADDI.
- EX_ADDR: same controls as EX_ADDI. Goes to MEM_RD if Op_i=100011, otherwise MEM_WR.
- EX_BEQ: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01, PCWrite=Zero_i -> IF.
- EX_J: PCSource=10, PCWrite=1 -> IF.
- MEM_RD: MemRead=1, IorD=1. Goes to WB_LW on mem_ready_i=1, else stays.
- MEM_WR: MemWrite=1, IorD=1. Goes to IF on mem_ready_i=1, else stays.
- WB_R: RegDst=1, MemtoReg=0, RegWrite=1 -> IF.
- WB_LW: RegDst=0, MemtoReg=1, RegWrite=1 -> IF.
- WB_ADDI: RegDst=0, MemtoReg=0, RegWrite=1 -> IF.
- Latency with zero wait states, in cycles: j/beq 3; R-type/addi/sw 4; lw 5. Each stalled memory cycle adds 1.
- Wait counter:
  - 8 bits wide; cleared on every state change and on reset.
  - Increments each cycle in IF, MEM_RD or MEM_WR while mem_ready_i=0.
  - If WAIT_MAX!=0 and the counter equals WAIT_MAX while mem_ready_i=0: next state is HALT and mem_timeout_o is set. mem_ready_i=1 in that same cycle takes priority (normal advance, no timeout).
- HALT: all controls 0, mem_timeout_o=1. Exits only through reset.
- Memory request signals hold steady until mem_ready_i. Requests never drop mid-stall except through reset.
- Reset asserted mid-instruction: immediate return to RST. No register or PC write may occur in the reset cycle.

Optional Feature:
- Macro MULTICYCLE_PERF_EN.
- When defined, adds two 32-bit output ports:
  - cycle_cnt_o: counts every clock edge not in RST or HALT.
  - instr_cnt_o: increments on each transition into IF from EX_BEQ, EX_J, MEM_WR or WB_*.
  - Both reset to 0 and wrap at 2^32.
- When undefined, the ports and counters are absent and the behaviour above is unchanged.

Test Plan:
- Reset release, mem_ready_i=1, Op_i=000000 -> state_o 0,1,2,3,10,1. IRWrite and PCWrite pulse in IF, RegWrite=1 and RegDst=1 in WB_R.
- lw (100011), mem_ready_i low for 3 cycles in MEM_RD -> MEM_RD held 4 cycles with MemRead=1, IorD=1; then WB_LW with MemtoReg=1. Total 8 cycles.
- beq (000100) with Zero_i=1, then again with Zero_i=0 -> PCWrite=1 with PCSource=01 in the first EX_BEQ, PCWrite=0 in the second. Each instruction takes 3 cycles.
- Op_i=111111 in ID -> illegal_o=1 for exactly one cycle, next state IF, no RegWrite or MemWrite asserted.
- WAIT_MAX=4, sw with mem_ready_i held 0 -> MEM_WR for 5 cycles, then HALT and mem_timeout_o=1 held. Asserting rst_i=0 returns state_o to 0 and clears the flag.
- MULTICYCLE_PERF_EN, program sequence j, addi, sw with no stalls -> instr_cnt_o=3, cycle_cnt_o=11.
